// File: rtl/rf_pkg.sv
// rf_pkg: shared definitions for the register file and its write-back scheduler.
// Holds the default geometry (data width, address width, requester count),
// the address/data types used by the register file, and a small modulo
// helper used by the round-robin arbiter.
package rf_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NREQ       = 3;

  typedef logic [ADDR_WIDTH-1:0] rf_addr_t;
  typedef logic [DATA_WIDTH-1:0] rf_data_t;

  // Single-step wrap: v is known to lie in 0..2n-2, so one subtraction suffices.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/rf_wb_scheduler_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with an internal rotating pointer.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   req[N]    - request vector
//   advance   - a grant was consumed this cycle; move pointer past the winner
//   gnt[N]    - one-hot grant (combinational), zero when req is zero
module rr_arbiter
  import rf_pkg::*;
#(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx_s;
  logic [PW-1:0] cand_s;
  logic          found_s;

  // Find the winner: scan the search order backwards so the last hit is the
  // first requester at or after the pointer.
  always_comb begin
    idx_s   = {PW{1'b0}};
    cand_s  = {PW{1'b0}};
    found_s = |req;
    for (int k = N - 1; k >= 0; k--) begin
      cand_s = PW'(rr_wrap(int'(ptr_q) + k, N));
      if (req[cand_s]) begin
        idx_s = cand_s;
      end else begin
        idx_s = idx_s;
      end
    end
    gnt = found_s ? (N'(1) << idx_s) : {N{1'b0}};
  end

  // Next pointer: one past the winner on a consumed grant, otherwise hold.
  always_comb begin
    if (advance && found_s) begin
      ptr_d = (idx_s == PW'(N - 1)) ? {PW{1'b0}} : (idx_s + PW'(1));
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= {PW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: shares the register file write port among NREQ producers
// with round-robin arbitration and keeps a per-register busy scoreboard.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   req_valid/req_addr/req_data  - packed per-requester write requests
//   req_ready                    - one-hot grant (combinational)
//   issue_valid/issue_addr       - destination reservation from issue
//   issue_ready                  - reservation accepted (destination not busy)
//   chk_addr1/2, chk_busy1/2     - source operand pending-write lookup
//   rf_wen/rf_waddr/rf_wdata     - registered register-file write port
module rf_wb_scheduler
  import rf_pkg::*;
#(
  parameter int NREQ       = rf_pkg::NREQ,
  parameter int DATA_WIDTH = rf_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = rf_pkg::ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       issue_valid,
  input  logic [ADDR_WIDTH-1:0]      issue_addr,
  output logic                       issue_ready,
  input  logic [ADDR_WIDTH-1:0]      chk_addr1,
  input  logic [ADDR_WIDTH-1:0]      chk_addr2,
  output logic                       chk_busy1,
  output logic                       chk_busy2,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  logic [NREQ-1:0]       gnt_s;
  logic                  xfer_s;
  logic [ADDR_WIDTH-1:0] sel_addr_s;
  logic [DATA_WIDTH-1:0] sel_data_s;

  logic                  wen_q, wen_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [NREG-1:0]       busy_q, busy_d;

  rr_arbiter #(.N(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (xfer_s),
    .gnt     (gnt_s)
  );

  // The grant is already qualified by valid, so any grant bit is a transfer.
  assign req_ready = gnt_s;
  assign xfer_s    = |gnt_s;

  // Mux the granted requester's address and data (grant is one-hot).
  always_comb begin
    sel_addr_s = {ADDR_WIDTH{1'b0}};
    sel_data_s = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      sel_addr_s = sel_addr_s | ({ADDR_WIDTH{gnt_s[i]}} & req_addr[i*ADDR_WIDTH +: ADDR_WIDTH]);
      sel_data_s = sel_data_s | ({DATA_WIDTH{gnt_s[i]}} & req_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // Write register next state; address 0 is consumed without a write.
  always_comb begin
    if (xfer_s) begin
      wen_d   = (sel_addr_s != {ADDR_WIDTH{1'b0}});
      waddr_d = sel_addr_s;
      wdata_d = sel_data_s;
    end else begin
      wen_d   = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
    end
  end

  // Scoreboard next state: clear on commit, then set on reservation so a
  // same-address collision resolves to busy. Entry 0 is never busy.
  always_comb begin
    busy_d = busy_q;
    if (wen_q) begin
      busy_d[waddr_q] = 1'b0;
    end else begin
      busy_d = busy_d;
    end
    if (issue_valid && issue_ready && (issue_addr != {ADDR_WIDTH{1'b0}})) begin
      busy_d[issue_addr] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
    busy_d[0] = 1'b0;
  end

  // Write port and scoreboard registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_q   <= 1'b0;
      waddr_q <= {ADDR_WIDTH{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
      busy_q  <= {NREG{1'b0}};
    end else begin
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
    end
  end

  // No bypass from the commit: busy still reads 1 during the rf_wen cycle.
  assign issue_ready = ~busy_q[issue_addr];
  assign chk_busy1   = busy_q[chk_addr1];
  assign chk_busy2   = busy_q[chk_addr2];

  assign rf_wen   = wen_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb_rf_wb_scheduler: directed self-checking bench for rf_wb_scheduler
// (NREQ=3, 32-bit data, 5-bit addresses).
module tb_rf_wb_scheduler;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               issue_valid;
  logic [AW-1:0]      issue_addr;
  logic               issue_ready;
  logic [AW-1:0]      chk_addr1;
  logic [AW-1:0]      chk_addr2;
  logic               chk_busy1;
  logic               chk_busy2;
  logic               rf_wen;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  rf_wb_scheduler #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .issue_ready (issue_ready),
    .chk_addr1   (chk_addr1),
    .chk_addr2   (chk_addr2),
    .chk_busy1   (chk_busy1),
    .chk_busy2   (chk_busy2),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    req_valid   = 3'b000;
    issue_valid = 1'b0;
    issue_addr  = 5'd0;
    chk_addr1   = 5'd0;
    chk_addr2   = 5'd0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    req_addr = '0;
    req_data = '0;
    do_reset();

    // Reset state
    check("rst_wen",    64'(rf_wen),      64'd0);
    check("rst_waddr",  64'(rf_waddr),    64'd0);
    check("rst_wdata",  64'(rf_wdata),    64'd0);
    check("rst_iready", 64'(issue_ready), 64'd1);
    check("rst_busy1",  64'(chk_busy1),   64'd0);
    check("rst_ready",  64'(req_ready),   64'd0);

    // Pointer wrap: ptr 0 -> grant 2 -> ptr 0 -> grant 0 -> ptr 1
    set_req(2, 5'd4, 32'h0000_0044);
    req_valid = 3'b100;
    #1 check("wrap_r2", 64'(req_ready), 64'h4);
    tick();
    check("wrap_wen2", 64'(rf_wen),   64'd1);
    check("wrap_wa2",  64'(rf_waddr), 64'd4);
    set_req(0, 5'd6, 32'h0000_0066);
    req_valid = 3'b001;
    #1 check("wrap_r0", 64'(req_ready), 64'h1);
    tick();
    check("wrap_wa0", 64'(rf_waddr), 64'd6);
    // ptr now 1: requester 1 wins over requester 0
    set_req(0, 5'd8, 32'h0000_0088);
    set_req(1, 5'd9, 32'h0000_0099);
    req_valid = 3'b011;
    #1 check("wrap_ptr1", 64'(req_ready), 64'h2);
    tick();
    check("wrap_wa1", 64'(rf_waddr), 64'd9);
    req_valid = 3'b001;
    #1 check("wrap_r0b", 64'(req_ready), 64'h1);
    tick();
    check("wrap_wa0b", 64'(rf_waddr), 64'd8);
    req_valid = 3'b000;
    #1 check("idle_ready", 64'(req_ready), 64'h0);
    tick();
    check("idle_wen",  64'(rf_wen),   64'd0);
    check("idle_hold", 64'(rf_waddr), 64'd8);

    // Single write: requester 1, addr 5, 0xDEADBEEF
    set_req(1, 5'd5, 32'hDEAD_BEEF);
    req_valid = 3'b010;
    #1 check("sw_ready", 64'(req_ready), 64'h2);
    tick();
    req_valid = 3'b000;
    check("sw_wen",   64'(rf_wen),   64'd1);
    check("sw_waddr", 64'(rf_waddr), 64'd5);
    check("sw_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    tick();
    check("sw_wen_off", 64'(rf_wen),   64'd0);
    check("sw_wdhold",  64'(rf_wdata), 64'hDEAD_BEEF);

    // Fairness from reset: grants 0,1,2 back to back
    do_reset();
    set_req(0, 5'd1, 32'h0000_0001);
    set_req(1, 5'd2, 32'h0000_0002);
    set_req(2, 5'd3, 32'h0000_0003);
    req_valid = 3'b111;
    #1 check("fair_g0", 64'(req_ready), 64'h1);
    tick();
    req_valid = 3'b110;
    check("fair_wa1", 64'(rf_waddr), 64'd1);
    #1 check("fair_g1", 64'(req_ready), 64'h2);
    tick();
    req_valid = 3'b100;
    check("fair_wen2", 64'(rf_wen),   64'd1);
    check("fair_wa2",  64'(rf_waddr), 64'd2);
    #1 check("fair_g2", 64'(req_ready), 64'h4);
    tick();
    req_valid = 3'b000;
    check("fair_wa3", 64'(rf_waddr), 64'd3);
    check("fair_wd3", 64'(rf_wdata), 64'd3);
    #1 check("fair_idle", 64'(req_ready), 64'h0);
    tick();
    check("fair_wen_off", 64'(rf_wen), 64'd0);

    // Scoreboard: reserve 7, then write back 7
    issue_valid = 1'b1;
    issue_addr  = 5'd7;
    #1 check("sb_iready_pre", 64'(issue_ready), 64'd1);
    tick();
    issue_valid = 1'b0;
    chk_addr1   = 5'd7;
    chk_addr2   = 5'd6;
    #1;
    check("sb_busy7",    64'(chk_busy1),   64'd1);
    check("sb_busy6",    64'(chk_busy2),   64'd0);
    check("sb_iready_7", 64'(issue_ready), 64'd0);
    set_req(0, 5'd7, 32'h0000_0777);
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    check("sb_wb_wen",  64'(rf_wen),    64'd1);
    check("sb_wb_busy", 64'(chk_busy1), 64'd1);
    tick();
    check("sb_cleared", 64'(chk_busy1),   64'd0);
    check("sb_iready",  64'(issue_ready), 64'd1);

    // Address 0: reservation ignored, request consumed without a write
    issue_valid = 1'b1;
    issue_addr  = 5'd0;
    tick();
    issue_valid = 1'b0;
    chk_addr1   = 5'd0;
    #1 check("a0_busy", 64'(chk_busy1), 64'd0);
    set_req(2, 5'd0, 32'h1234_5678);
    req_valid = 3'b100;
    #1 check("a0_ready", 64'(req_ready), 64'h4);
    tick();
    req_valid = 3'b000;
    check("a0_wen", 64'(rf_wen), 64'd0);

    // Asynchronous reset in the middle of a write
    issue_valid = 1'b1;
    issue_addr  = 5'd9;
    tick();
    issue_valid = 1'b0;
    chk_addr1   = 5'd9;
    set_req(0, 5'd3, 32'h0000_0033);
    req_valid = 3'b001;
    tick();
    req_valid = 3'b000;
    check("ar_wen_pre",  64'(rf_wen),    64'd1);
    check("ar_busy_pre", 64'(chk_busy1), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("ar_wen",    64'(rf_wen),      64'd0);
    check("ar_waddr",  64'(rf_waddr),    64'd0);
    check("ar_wdata",  64'(rf_wdata),    64'd0);
    check("ar_busy",   64'(chk_busy1),   64'd0);
    issue_addr = 5'd9;
    #1 check("ar_iready", 64'(issue_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Write-back scheduler for the 32x32 register file. Shares the register file's single write port among `NREQ` result producers (ALU, load unit, mul/div) using round-robin arbitration with valid/ready handshakes. Keeps a per-register busy scoreboard so issue logic can detect pending writes. Sits between the execution units and the register file write port (`wen`/`waddr`/`wdata`).

## Interface
- `NREQ`, 3: number of write-back requesters (2..8).
- `DATA_WIDTH`, 32: register data width.
- `ADDR_WIDTH`, 5: register address width; the file holds 2^`ADDR_WIDTH` entries.

- `clk`  in  1  rising-edge clock; one clock domain.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  NREQ  per-requester write request.
- `req_addr`  in  NREQ*ADDR_WIDTH  destination register; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_data`  in  NREQ*DATA_WIDTH  write data; packed the same way as `req_addr`.
- `req_ready`  out  NREQ  one-hot grant (combinational).
- `issue_valid`  in  1  issue stage reserves a destination.
- `issue_addr`  in  ADDR_WIDTH  destination being reserved.
- `issue_ready`  out  1  reservation may be accepted (combinational).
- `chk_addr1`, `chk_addr2`  in  ADDR_WIDTH  source operands to check.
- `chk_busy1`, `chk_busy2`  out  1  source has a pending write (combinational).
- `rf_wen`  out  1  to register file `wen` (registered).
- `rf_waddr`  out  ADDR_WIDTH  to register file `waddr` (registered).
- `rf_wdata`  out  DATA_WIDTH  to register file `wdata` (registered).

## Operation
- Handshake: a transfer from requester i occurs when `req_valid[i] & req_ready[i]`.
  - A requester holds `valid`, `addr` and `data` stable until its transfer completes.
  - `req_ready` never depends on future cycles. At most one bit is set. It is zero when `req_valid` is zero.
- Arbitration: round-robin pointer `ptr` (0..NREQ-1, reset 0).
  - Search order is ptr, ptr+1, …, wrapping mod NREQ. The first valid requester found is granted.
  - On a grant to i, `ptr <= (i+1) mod NREQ`. With no grant, `ptr` holds.
  - A requester that stays valid is granted within NREQ cycles (no starvation).
- Write register: on a transfer, the next edge loads `rf_waddr`/`rf_wdata` with the granted address/data.
  - `rf_wen` loads 1 unless the address is 0.
  - With no transfer, `rf_wen` loads 0; `rf_waddr`/`rf_wdata` hold.
- Address 0: address-0 requests are granted and consumed, but `rf_wen` stays 0 and the scoreboard is untouched.
- Scoreboard: `busy[2^ADDR_WIDTH]`, all 0 at reset; bit 0 is constant 0.
  - Set: `issue_valid & issue_ready & issue_addr!=0` sets `busy[issue_addr]`.
  - Clear: `rf_wen` high clears `busy[rf_waddr]` at the same edge the register file commits.
  - If set and clear target the same address in one cycle, set wins. This cannot occur through legal use, because `issue_ready` is 0 for that address.
- `issue_ready = ~busy[issue_addr]`. This blocks write-after-write; the issue stage stalls while it is low.
- `chk_busyN = busy[chk_addrN]`. There is no bypass from `rf_wen`: in the commit cycle the bit still reads 1. From the next cycle the register file returns the new data and busy reads 0.
- Requests to non-busy registers are legal (no scoreboard check on the write side).

## Timing
- Reset values: `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0, `ptr`=0, all `busy`=0.
  - `req_ready` and `issue_ready` follow combinationally: `issue_ready`=1 after reset.
  - Reset asserted mid-operation discards any registered write (`rf_wen` drops immediately) and clears the scoreboard.
- Latency: transfer in cycle N, then `rf_wen` high in cycle N+1, then register file updated at the end of N+1, then new value readable in cycle N+2.
- Throughput: one write per cycle, sustained.
- Scoreboard: issue accepted in cycle N gives `busy` = 1 from cycle N+1.

## Structure
- Shared package `rf_pkg`: `DATA_WIDTH`, `ADDR_WIDTH`, `NREQ` defaults and the `rf_addr_t` / `rf_data_t` types, shared with the register file.
- Sub-module `rr_arbiter` (parameter `N`; inputs `req[N]`, `advance`; outputs one-hot `gnt[N]`). It holds `ptr` internally.
- The top level holds the write register and the scoreboard.

## Test plan
- Reset: hold `rst` mid-stream with `rf_wen`=1 → `rf_wen`=0, `rf_waddr`=0, `rf_wdata`=0 asynchronously; `issue_ready`=1; `chk_busy*`=0.
- Single write: requester 1 valid, addr 5, data 0xDEADBEEF in cycle N → `req_ready`=3'b010 in N; `rf_wen`=1, `rf_waddr`=5, `rf_wdata`=0xDEADBEEF in N+1 only.
- Fairness: all three requesters held valid (addrs 1, 2, 3) from reset → grants 0, 1, 2, then idle; `rf_waddr` sequence 1, 2, 3 in consecutive cycles.
- Scoreboard:
  - Issue addr 7 → `chk_busy1`=1 for `chk_addr1`=7, and `issue_ready`=0 for `issue_addr`=7.
  - Write-back of addr 7 → busy reads 1 during the `rf_wen` cycle and 0 the cycle after.
- Address 0: issue addr 0 → `busy` is unchanged. Request with addr 0 → `req_ready` asserted, `rf_wen` stays 0.
- Pointer wrap: only requester 2 valid, then only requester 0 → both granted immediately; `ptr` goes 0, 0, then 1.
